// File: rtl/quantum_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : quantum_int_ctrl
// Description : Preemption-quantum timer; counts retired instructions and
//               holds an interrupt request with captured return PC until ack.
//               Optional macro QNT_AUTO_RELOAD_EN re-arms from the last quantum.
// Revision    : 1.0 - initial release
// ============================================================================
module quantum_int_ctrl #(
    parameter int DATA_W = 32,
    parameter int QNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instrValid_i,
    input  logic              halt_i,
    input  logic              stopQnt_i,
    input  logic              writeI_i,
    input  logic [DATA_W-1:0] writeData_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic              intSig_o,
    output logic [DATA_W-1:0] epc_o,
    output logic [QNT_W-1:0]  qntRemaining_o,
    output logic              armed_o
);

    localparam logic [QNT_W-1:0]  c_QNT_ONE = QNT_W'(1);
    localparam logic [DATA_W-1:0] c_PC_ONE  = DATA_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_PEND  = 2'd2
`ifdef QNT_AUTO_RELOAD_EN
        , S_HOLD = 2'd3
`endif
    } state_t;

    state_t             r_state;
    logic [QNT_W-1:0]   r_counter;
    logic [DATA_W-1:0]  r_epc;
    logic               r_int;
    logic               r_armed;
`ifdef QNT_AUTO_RELOAD_EN
    logic [QNT_W-1:0]   r_reload;
`endif

    logic [QNT_W-1:0]   w_load;
    logic               w_load_nz;
    logic               w_dec;
    logic               w_last;

    assign w_load    = writeData_i[QNT_W-1:0];
    assign w_load_nz = |w_load;
    assign w_dec     = instrValid_i & ~halt_i;
    assign w_last    = (r_counter == c_QNT_ONE);

    // Operand bits above the quantum width carry no meaning for the timer.
    generate
        if (DATA_W > QNT_W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^writeData_i[DATA_W-1:QNT_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
            r_epc     <= '0;
            r_int     <= 1'b0;
            r_armed   <= 1'b0;
`ifdef QNT_AUTO_RELOAD_EN
            r_reload  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (writeI_i && w_load_nz) begin
                        r_counter <= w_load;
`ifdef QNT_AUTO_RELOAD_EN
                        r_reload  <= w_load;
`endif
                        r_state   <= S_COUNT;
                        r_armed   <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (stopQnt_i) begin
                        r_state <= S_IDLE;
                        r_armed <= 1'b0;
                    end else if (writeI_i) begin
                        if (w_load_nz) begin
                            r_counter <= w_load;
`ifdef QNT_AUTO_RELOAD_EN
                            r_reload  <= w_load;
`endif
                        end else begin
                            r_state <= S_IDLE;
                            r_armed <= 1'b0;
                        end
                    end else if (w_dec) begin
                        r_counter <= r_counter - c_QNT_ONE;
                        if (w_last) begin
                            r_epc   <= pc_i + c_PC_ONE;
                            r_state <= S_PEND;
                            r_int   <= 1'b1;
                            r_armed <= 1'b0;
                        end
                    end
                end
                S_PEND: begin
                    // Level request stays up regardless of halt, retires or writei.
                    if (stopQnt_i) begin
                        r_int <= 1'b0;
`ifdef QNT_AUTO_RELOAD_EN
                        r_counter <= r_reload;
                        r_state   <= S_HOLD;
                        r_armed   <= 1'b1;
`else
                        r_state   <= S_IDLE;
`endif
                    end
                end
`ifdef QNT_AUTO_RELOAD_EN
                S_HOLD: begin
                    // Re-armed but frozen until the OS releases it.
                    if (writeI_i) begin
                        if (w_load_nz) begin
                            r_state <= S_COUNT;
                        end else begin
                            r_state <= S_IDLE;
                            r_armed <= 1'b0;
                        end
                    end else if (stopQnt_i) begin
                        r_state <= S_COUNT;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_int   <= 1'b0;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign intSig_o       = r_int;
    assign epc_o          = r_epc;
    assign qntRemaining_o = r_counter;
    assign armed_o        = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_quantum_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_quantum_int_ctrl
// Description : Scoreboard bench for quantum_int_ctrl against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quantum_int_ctrl;

    localparam int DATA_W = 32;
    localparam int QNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              instrValid_i;
    logic              halt_i;
    logic              stopQnt_i;
    logic              writeI_i;
    logic [DATA_W-1:0] writeData_i;
    logic [DATA_W-1:0] pc_i;
    logic              intSig_o;
    logic [DATA_W-1:0] epc_o;
    logic [QNT_W-1:0]  qntRemaining_o;
    logic              armed_o;

    quantum_int_ctrl #(.DATA_W(DATA_W), .QNT_W(QNT_W)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instrValid_i   (instrValid_i),
        .halt_i         (halt_i),
        .stopQnt_i      (stopQnt_i),
        .writeI_i       (writeI_i),
        .writeData_i    (writeData_i),
        .pc_i           (pc_i),
        .intSig_o       (intSig_o),
        .epc_o          (epc_o),
        .qntRemaining_o (qntRemaining_o),
        .armed_o        (armed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              irq;
        logic [DATA_W-1:0] epc;
        logic [QNT_W-1:0]  cnt;
        logic              armed;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: 0 idle, 1 counting, 2 pending, 3 holdoff
    int                m_st  = 0;
    logic [QNT_W-1:0]  m_cnt = '0;
    logic [QNT_W-1:0]  m_rel = '0;
    logic [DATA_W-1:0] m_epc = '0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = '0; m_rel = '0; m_epc = '0;
    endtask

    task automatic model_step(input logic iv, input logic h, input logic sq,
                              input logic wi, input logic [DATA_W-1:0] wd,
                              input logic [DATA_W-1:0] pc);
        logic [QNT_W-1:0] l;
        l = wd[QNT_W-1:0];
        case (m_st)
            0: if (wi && l != 0) begin m_cnt = l; m_rel = l; m_st = 1; end
            1: begin
                if (sq) m_st = 0;
                else if (wi) begin
                    if (l == 0) m_st = 0;
                    else begin m_cnt = l; m_rel = l; end
                end else if (iv && !h) begin
                    m_cnt = m_cnt - 1'b1;
                    if (m_cnt == 0) begin m_epc = pc + 32'd1; m_st = 2; end
                end
            end
            2: if (sq) begin
`ifdef QNT_AUTO_RELOAD_EN
                m_cnt = m_rel; m_st = 3;
`else
                m_st = 0;
`endif
            end
            default: begin
                if (wi) m_st = (l == 0) ? 0 : 1;
                else if (sq) m_st = 1;
            end
        endcase
    endtask

    // One clock: drive at negedge, push model expectation, compare after posedge.
    task automatic cyc(input logic iv, input logic h, input logic sq,
                       input logic wi, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] pc);
        exp_t e;
        @(negedge clk);
        instrValid_i = iv; halt_i = h; stopQnt_i = sq;
        writeI_i = wi; writeData_i = wd; pc_i = pc;
        model_step(iv, h, sq, wi, wd, pc);
        e.irq = (m_st == 2); e.epc = m_epc; e.cnt = m_cnt;
        e.armed = (m_st == 1) || (m_st == 3);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("intSig", {31'd0, intSig_o}, {31'd0, e.irq});
            check("epc", epc_o, e.epc);
            check("qnt", {16'd0, qntRemaining_o}, {16'd0, e.cnt});
            check("armed", {31'd0, armed_o}, {31'd0, e.armed});
        end
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic retire(input logic [DATA_W-1:0] pc);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, pc);
    endtask

    task automatic arm(input logic [DATA_W-1:0] l);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, l, '0);
    endtask

    task automatic ack();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0; instrValid_i = 1'b0; halt_i = 1'b0; stopQnt_i = 1'b0;
        writeI_i = 1'b0; writeData_i = '0; pc_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_int", {31'd0, intSig_o}, 32'd0);
        check("rst_epc", epc_o, 32'd0);
        check("rst_qnt", {16'd0, qntRemaining_o}, 32'd0);
        check("rst_armed", {31'd0, armed_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Basic expiry at quantum 3
        arm(32'd3);
        retire(32'h10); retire(32'h11); retire(32'h12);
        check("t1_int", {31'd0, intSig_o}, 32'd1);
        check("t1_epc", epc_o, 32'h13);
        check("t1_qnt", {16'd0, qntRemaining_o}, 32'd0);

        // Held level in PEND while retiring and with ignored writei
        repeat (5) retire($urandom());
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'd9, 32'h40);
        check("t2_int_held", {31'd0, intSig_o}, 32'd1);
        check("t2_epc_held", epc_o, 32'h13);
        ack();
        check("t2_int_ack", {31'd0, intSig_o}, 32'd0);
        check("t2_armed_ack", {31'd0, armed_o}, 32'd0);

        // Halt freezes counting
        arm(32'd4);
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, 32'h100);
        check("t3_qnt_halt", {16'd0, qntRemaining_o}, 32'd4);
        retire(32'h200); retire(32'h201); retire(32'h202);
        check("t3_no_irq", {31'd0, intSig_o}, 32'd0);
        retire(32'h203);
        check("t3_irq", {31'd0, intSig_o}, 32'd1);
        check("t3_epc", epc_o, 32'h204);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        check("t3_ack_halt", {31'd0, intSig_o}, 32'd0);

        // Reload wins over a coincident retire
        arm(32'd5);
        retire(32'h300); retire(32'h301);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'd7, 32'h302);
        check("t4_reload", {16'd0, qntRemaining_o}, 32'd7);
        repeat (6) retire(32'h310);
        check("t4_no_irq", {31'd0, intSig_o}, 32'd0);
        retire(32'h320);
        check("t4_irq", {31'd0, intSig_o}, 32'd1);
        check("t4_epc", epc_o, 32'h321);
        ack();
        arm(32'd5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0001_0000, '0);
        check("t4_disarm", {31'd0, armed_o}, 32'd0);
        check("t4_epc_kept", epc_o, 32'h321);

        // Upper operand bits ignored; quantum of 1 with PC wrap
        arm(32'hABCD_0001);
        check("t5_armed", {31'd0, armed_o}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 32'h500);
        check("t5_stop_prio", {31'd0, armed_o}, 32'd0);
        check("t5_stop_cnt", {16'd0, qntRemaining_o}, 32'd1);
        arm(32'd1);
        retire(32'hFFFF_FFFF);
        check("t5_epc_wrap", epc_o, 32'd0);
        ack();

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 9) == 0),
                32'($urandom_range(0, 6)), $urandom());
        end
        ack(); ack(); ack();

        // Asynchronous reset mid-PEND
        arm(32'd1);
        retire(32'h700);
        check("t6_pend", {31'd0, intSig_o}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_int", {31'd0, intSig_o}, 32'd0);
        check("t6_rst_epc", epc_o, 32'd0);
        check("t6_rst_qnt", {16'd0, qntRemaining_o}, 32'd0);
        check("t6_rst_armed", {31'd0, armed_o}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ack();
        check("t6_idle_stop", {31'd0, armed_o}, 32'd0);
        idle_cyc();

`ifdef QNT_AUTO_RELOAD_EN
        // Auto reload: holdoff after ack, released by writei
        arm(32'd2);
        retire(32'h800); retire(32'h801);
        check("t7_irq", {31'd0, intSig_o}, 32'd1);
        ack();
        check("t7_cnt_reload", {16'd0, qntRemaining_o}, 32'd2);
        check("t7_armed", {31'd0, armed_o}, 32'd1);
        repeat (3) retire(32'h810);
        check("t7_holdoff", {16'd0, qntRemaining_o}, 32'd2);
        arm(32'd9);
        retire(32'h820);
        check("t7_no_irq", {31'd0, intSig_o}, 32'd0);
        retire(32'h821);
        check("t7_irq2", {31'd0, intSig_o}, 32'd1);
        ack();
        ack();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quantum_int_ctrl.md
Name: quantum_int_ctrl

Overview:
- Preemption-quantum timer and interrupt requester directly upstream of the control decoder.
- Counts retired instructions once armed by the OS, raises the interrupt request that the decoder samples on its intSig input, and captures the return PC.
- The request is held until the decoder acknowledges with stopQnt.
- The OS re-arms the timer through the writei instruction, which drives WriteI.

Parameters:
- DATA_W, 32, width of PC and write-data buses
- QNT_W, 16, width of quantum counter; WriteI loads writeData_i[QNT_W-1:0]

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- instrValid_i  input  1  one instruction retires this cycle (PC advances)
- halt_i  input  1  Halt from control decoder; freezes counting
- stopQnt_i  input  1  stopQnt from control decoder; interrupt acknowledge / disarm
- writeI_i  input  1  WriteI from control decoder; load quantum and arm
- writeData_i  input  DATA_W  register operand carried by writei
- pc_i  input  DATA_W  PC of the instruction retiring this cycle
- intSig_o  output  1  interrupt request to the control decoder
- epc_o  output  DATA_W  PC captured at expiry (return address)
- qntRemaining_o  output  QNT_W  current counter value
- armed_o  output  1  high in COUNT state

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter=0, reload=0, intSig_o=0, epc_o=0, armed_o=0. Reset mid-COUNT or mid-PEND drops intSig_o immediately, not at the next edge.
- FSM states:
  - IDLE: disarmed.
  - COUNT: armed, decrementing.
  - PEND: intSig_o=1, waiting for acknowledge.
- IDLE:
  - writeI_i=1 with load value L=writeData_i[QNT_W-1:0] != 0: next cycle counter=L, reload=L, state COUNT.
  - L==0: stays IDLE.
  - stopQnt_i ignored.
- COUNT:
  - Decrement enable: dec = instrValid_i & ~halt_i.
  - Priority, highest first:
    1. stopQnt_i: go to IDLE, counter unchanged.
    2. writeI_i: reload with L; L==0 goes to IDLE.
    3. dec with counter==1: counter becomes 0, epc_o<=pc_i+1, state PEND.
    4. dec: counter-1.
  - Latency: the Nth retired instruction after arming with L=N raises intSig_o on the following cycle.
- PEND:
  - intSig_o=1, held level (the decoder is level-sensitive).
  - writeI_i and dec ignored; counter stays 0; epc_o frozen.
  - stopQnt_i=1: next cycle state IDLE, intSig_o=0.
  - halt_i does not block PEND.
- intSig_o and armed_o are registered decodes of the state; no combinational path from inputs to outputs.
- epc_o holds its value until the next expiry and is not cleared by stopQnt or writei.
- Arithmetic: pc_i+1 wraps modulo 2^DATA_W; counter never underflows (0 only reachable via expiry).
- reload is a register reserved for the optional feature; unused otherwise.

Optional Feature:
- QNT_AUTO_RELOAD_EN
- Defined:
  - On leaving PEND via stopQnt_i, load counter=reload and keep armed.
  - Next state is a holdoff: armed_o=1, no decrement, until a writei (value ignored, L==0 still disarms) or a second stopQnt releases it to COUNT.
  - OS does not need to rewrite the quantum.
- Undefined: behaviour exactly as above; PEND -> IDLE, reload register unused and removable.

Test Plan:
- Arm with writeData_i=3, assert instrValid_i 3 cycles, pc_i=0x10,0x11,0x12 -> intSig_o=1 one cycle after third retire, epc_o=0x13, qntRemaining_o=0.
- In PEND hold stopQnt_i=0 for 5 cycles with instrValid_i=1 -> intSig_o stays 1, epc_o stays 0x13; then stopQnt_i=1 -> intSig_o=0, armed_o=0 next cycle.
- Arm with 4, retire with halt_i=1 for 10 cycles -> counter stays 4; release halt -> expiry after 4 retires.
- Arm with 5, retire 2, writeI_i=1 with 7 coinciding with a retire -> counter=7 (reload wins), no expiry until 7 more retires; writeI with 0 -> armed_o=0.
- Assert rst_n=0 asynchronously mid-PEND -> intSig_o, epc_o, qntRemaining_o, armed_o all 0 before next clk edge; stopQnt_i in IDLE -> no change.
- With QNT_AUTO_RELOAD_EN: arm 2, expire, ack -> counter=2, armed_o=1, no decrement until writei; then expiry after 2 retires.
